// File: rtl/lcd_timing_pkg.sv
// Shared timing sets, RGB565 colours and state encoding for the LCD timing generator.
`timescale 1ns/1ps
package lcd_timing_pkg;

  localparam int CNT_W = 11;

  typedef struct packed {
    logic [CNT_W-1:0] sync;
    logic [CNT_W-1:0] back;
    logic [CNT_W-1:0] disp;
    logic [CNT_W-1:0] front;
  } axis_timing_t;

  localparam axis_timing_t VGA640_H = '{sync: 11'd96,  back: 11'd48, disp: 11'd640, front: 11'd16};
  localparam axis_timing_t VGA640_V = '{sync: 11'd2,   back: 11'd33, disp: 11'd480, front: 11'd10};
  localparam axis_timing_t SVGA_H   = '{sync: 11'd128, back: 11'd88, disp: 11'd800, front: 11'd40};
  localparam axis_timing_t SVGA_V   = '{sync: 11'd4,   back: 11'd23, disp: 11'd600, front: 11'd1};
  localparam axis_timing_t LCD480_H = '{sync: 11'd41,  back: 11'd2,  disp: 11'd480, front: 11'd2};
  localparam axis_timing_t LCD480_V = '{sync: 11'd10,  back: 11'd2,  disp: 11'd272, front: 11'd2};

  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lcd_state_e;

  function automatic int axis_total(input axis_timing_t t);
    return int'(t.sync) + int'(t.back) + int'(t.disp) + int'(t.front);
  endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// One timing axis: wrapping position counter plus sync / active / active-early window decodes.
`timescale 1ns/1ps
module lcd_axis_cnt
  import lcd_timing_pkg::*;
#(
  parameter int SYNC  = 96,
  parameter int BACK  = 48,
  parameter int DISP  = 640,
  parameter int FRONT = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             sync_o,
  output logic             active_o,
  output logic             active_early_o
);

  localparam int               TOTAL    = SYNC + BACK + DISP + FRONT;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] ACT_LO   = CNT_W'(SYNC + BACK);
  localparam logic [CNT_W-1:0] ACT_HI   = CNT_W'(SYNC + BACK + DISP);
  localparam logic [CNT_W-1:0] ERL_LO   = CNT_W'(SYNC + BACK - 1);
  localparam logic [CNT_W-1:0] ERL_HI   = CNT_W'(SYNC + BACK + DISP - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // The early window leads the active window by one count so a registered source lines up.
  assign cnt_o          = cnt_q;
  assign wrap_o         = (cnt_q == LAST);
  assign sync_o         = (cnt_q < SYNC_END);
  assign active_o       = (cnt_q >= ACT_LO) && (cnt_q < ACT_HI);
  assign active_early_o = (cnt_q >= ERL_LO) && (cnt_q < ERL_HI);

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD/VGA timing generator: hsync/vsync/de decode, one-clock-ahead pixel requests, RGB pass-through.
`timescale 1ns/1ps
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic        disp_en,
  input  logic [15:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [CNT_W-1:0] X_OFF = CNT_W'(H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] Y_OFF = CNT_W'(V_SYNC + V_BACK);

  if (H_TOTAL > 2047 || V_TOTAL > 2047 ||
      H_SYNC < 1 || H_BACK < 1 || H_DISP < 1 || H_FRONT < 1 ||
      V_SYNC < 1 || V_BACK < 1 || V_DISP < 1 || V_FRONT < 1) begin : g_param_check
    $error("lcd_timing_gen: porch/sync counts must be >= 1 and totals <= 2047");
  end

  lcd_state_e       state_q;
  logic             run;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, h_sync, h_act, h_early;
  logic             v_wrap, v_sync, v_act, v_early_unused;
  logic             data_req;

  assign run = (state_q == ST_RUN);

  // A frame only ends after its last pixel clock, so a mid-frame disable is deferred to here.
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (disp_en) state_q <= ST_RUN;
        ST_RUN:  if (h_wrap && v_wrap && !disp_en) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  lcd_axis_cnt #(.SYNC(H_SYNC), .BACK(H_BACK), .DISP(H_DISP), .FRONT(H_FRONT)) u_h_cnt (
    .clk_i          (lcd_pclk),
    .rst_ni         (rst_n),
    .clr_i          (!run),
    .en_i           (run),
    .cnt_o          (h_cnt),
    .wrap_o         (h_wrap),
    .sync_o         (h_sync),
    .active_o       (h_act),
    .active_early_o (h_early)
  );

  lcd_axis_cnt #(.SYNC(V_SYNC), .BACK(V_BACK), .DISP(V_DISP), .FRONT(V_FRONT)) u_v_cnt (
    .clk_i          (lcd_pclk),
    .rst_ni         (rst_n),
    .clr_i          (!run),
    .en_i           (run && h_wrap),
    .cnt_o          (v_cnt),
    .wrap_o         (v_wrap),
    .sync_o         (v_sync),
    .active_o       (v_act),
    .active_early_o (v_early_unused)
  );

  assign data_req    = run && h_early && v_act;
  assign lcd_hs      = !(run && h_sync);
  assign lcd_vs      = !(run && v_sync);
  assign lcd_de      = run && h_act && v_act;
  assign pixel_xpos  = data_req ? (h_cnt - X_OFF) : '0;
  assign pixel_ypos  = data_req ? (v_cnt - Y_OFF) : '0;
  assign lcd_rgb     = lcd_de ? pixel_data : 16'h0000;
  assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
  assign h_disp      = CNT_W'(H_DISP);
  assign v_disp      = CNT_W'(V_DISP);

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench: small-parameter instance against a cycle model + pixel scoreboard, default instance via vector table.
`timescale 1ns/1ps
module tb_lcd_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en_sm, en_df;
  logic [15:0] pd_sm, pd_df;
  logic [10:0] sm_x, sm_y, sm_hd, sm_vd, df_x, df_y, df_hd, df_vd;
  logic        sm_hs, sm_vs, sm_de, sm_fs, df_hs, df_vs, df_de, df_fs;
  logic [15:0] sm_rgb, df_rgb;

  lcd_timing_gen #(
    .H_SYNC(2), .H_BACK(1), .H_DISP(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1)
  ) u_sm (
    .lcd_pclk(clk), .rst_n(rst_n), .disp_en(en_sm), .pixel_data(pd_sm),
    .pixel_xpos(sm_x), .pixel_ypos(sm_y), .h_disp(sm_hd), .v_disp(sm_vd),
    .lcd_hs(sm_hs), .lcd_vs(sm_vs), .lcd_de(sm_de), .lcd_rgb(sm_rgb), .frame_start(sm_fs)
  );

  lcd_timing_gen u_df (
    .lcd_pclk(clk), .rst_n(rst_n), .disp_en(en_df), .pixel_data(pd_df),
    .pixel_xpos(df_x), .pixel_ypos(df_y), .h_disp(df_hd), .v_disp(df_vd),
    .lcd_hs(df_hs), .lcd_vs(df_vs), .lcd_de(df_de), .lcd_rgb(df_rgb), .frame_start(df_fs)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat(input logic [10:0] x, input logic [10:0] y);
    return {x[4:0], y[5:0], x[4:0]};
  endfunction

  // Registered pattern sources answer each coordinate request one clock later.
  always @(posedge clk) begin
    pd_sm <= pat(sm_x, sm_y);
    pd_df <= pat(df_x, df_y);
  end

  // Reference model of the small instance: H total 8 (sync 0-1, de 3-6), V total 6 (sync 0, de 2-4).
  localparam int SH_T = 8;
  localparam int SV_T = 6;
  logic m_run;
  int   m_h, m_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_h <= 0; m_v <= 0;
    end else if (!m_run) begin
      m_run <= en_sm; m_h <= 0; m_v <= 0;
    end else begin
      if (m_h == SH_T-1 && m_v == SV_T-1 && !en_sm) m_run <= 1'b0;
      m_h <= (m_h == SH_T-1) ? 0 : m_h + 1;
      if (m_h == SH_T-1) m_v <= (m_v == SV_T-1) ? 0 : m_v + 1;
    end
  end

  logic [15:0] sb_q[$];
  bit          sm_chk_on = 1'b0;
  int          cyc = 0, fs_last = -1, fs_cnt_sm = 0, de_cnt_sm = 0;

  always @(negedge clk) begin
    bit e_de, e_req;
    int ex, ey;
    cyc++;
    if (!rst_n) sb_q.delete();
    if (sm_chk_on) begin
      e_de  = m_run && m_h >= 3 && m_h < 7 && m_v >= 2 && m_v < 5;
      e_req = m_run && m_h >= 2 && m_h < 6 && m_v >= 2 && m_v < 5;
      ex = e_req ? m_h - 2 : 0;
      ey = e_req ? m_v - 2 : 0;
      chk("sm_hs", {31'd0, sm_hs}, {31'd0, !(m_run && m_h < 2)});
      chk("sm_vs", {31'd0, sm_vs}, {31'd0, !(m_run && m_v < 1)});
      chk("sm_de", {31'd0, sm_de}, {31'd0, e_de});
      chk("sm_xpos", {21'd0, sm_x}, ex);
      chk("sm_ypos", {21'd0, sm_y}, ey);
      chk("sm_frame_start", {31'd0, sm_fs}, {31'd0, (m_run && m_h == 0 && m_v == 0)});
      if (e_de) begin
        if (sb_q.size() == 0) chk("sm_scoreboard_empty", 32'd1, 32'd0);
        else                  chk("sm_rgb", {16'd0, sm_rgb}, {16'd0, sb_q.pop_front()});
      end else begin
        chk("sm_rgb_blank", {16'd0, sm_rgb}, 32'd0);
      end
      if (e_req) sb_q.push_back(pat(11'(ex), 11'(ey)));
    end
    if (sm_de) de_cnt_sm++;
    if (!m_run) fs_last = -1;
    if (sm_fs) begin
      if (fs_last >= 0) chk("sm_frame_period", cyc - fs_last, 32'd48);
      fs_last = cyc;
      fs_cnt_sm++;
    end
  end

  typedef struct {
    int          h;
    int          v;
    logic        hs;
    logic        vs;
    logic        de;
    int          x;
    int          y;
    logic [15:0] rgb;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];

  task automatic check_idle_sm(input string tag);
    chk({tag, "_hs"}, {31'd0, sm_hs}, 32'd1);
    chk({tag, "_vs"}, {31'd0, sm_vs}, 32'd1);
    chk({tag, "_de"}, {31'd0, sm_de}, 32'd0);
    chk({tag, "_rgb"}, {16'd0, sm_rgb}, 32'd0);
    chk({tag, "_xpos"}, {21'd0, sm_x}, 32'd0);
    chk({tag, "_ypos"}, {21'd0, sm_y}, 32'd0);
    chk({tag, "_fs"}, {31'd0, sm_fs}, 32'd0);
  endtask

  initial begin
    int idx, fs_before, de_before, hs_low, de_run, last_fall, n_fall, t_end;
    bit found, prev_hs;

    tbl[0]  = '{h:0,   v:0,  hs:0, vs:0, de:0, x:0,   y:0, rgb:16'h0000};
    tbl[1]  = '{h:95,  v:0,  hs:0, vs:0, de:0, x:0,   y:0, rgb:16'h0000};
    tbl[2]  = '{h:96,  v:0,  hs:1, vs:0, de:0, x:0,   y:0, rgb:16'h0000};
    tbl[3]  = '{h:799, v:1,  hs:1, vs:0, de:0, x:0,   y:0, rgb:16'h0000};
    tbl[4]  = '{h:0,   v:2,  hs:0, vs:1, de:0, x:0,   y:0, rgb:16'h0000};
    tbl[5]  = '{h:144, v:34, hs:1, vs:1, de:0, x:0,   y:0, rgb:16'h0000};
    tbl[6]  = '{h:143, v:35, hs:1, vs:1, de:0, x:0,   y:0, rgb:16'h0000};
    tbl[7]  = '{h:144, v:35, hs:1, vs:1, de:1, x:1,   y:0, rgb:16'h0000};
    tbl[8]  = '{h:145, v:35, hs:1, vs:1, de:1, x:2,   y:0, rgb:16'h0801};
    tbl[9]  = '{h:782, v:35, hs:1, vs:1, de:1, x:639, y:0, rgb:16'hF01E};
    tbl[10] = '{h:783, v:35, hs:1, vs:1, de:1, x:0,   y:0, rgb:16'hF81F};
    tbl[11] = '{h:784, v:35, hs:1, vs:1, de:0, x:0,   y:0, rgb:16'h0000};
    tbl[12] = '{h:143, v:36, hs:1, vs:1, de:0, x:0,   y:1, rgb:16'h0000};
    tbl[13] = '{h:144, v:36, hs:1, vs:1, de:1, x:1,   y:1, rgb:16'h0020};

    rst_n = 1'b0; en_sm = 1'b0; en_df = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_df_hs", {31'd0, df_hs}, 32'd1);
    chk("rst_df_vs", {31'd0, df_vs}, 32'd1);
    chk("rst_df_de", {31'd0, df_de}, 32'd0);
    chk("rst_df_rgb", {16'd0, df_rgb}, 32'd0);
    chk("rst_df_fs", {31'd0, df_fs}, 32'd0);
    chk("df_h_disp", {21'd0, df_hd}, 32'd640);
    chk("df_v_disp", {21'd0, df_vd}, 32'd480);
    chk("sm_h_disp", {21'd0, sm_hd}, 32'd4);
    chk("sm_v_disp", {21'd0, sm_vd}, 32'd3);
    check_idle_sm("rst_sm");
    sm_chk_on = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Enable latency: frame_start and hsync low one clock after disp_en is sampled.
    repeat (20) @(posedge clk);
    #1 en_sm = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("sm_enable_fs", {31'd0, sm_fs}, 32'd1);
    chk("sm_enable_hs", {31'd0, sm_hs}, 32'd0);
    repeat (3*48) @(posedge clk);

    // Disable at the start of line 3: rows 3 and 4 still complete, then no more frames.
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (m_run && m_v == 3 && m_h == 0) begin found = 1'b1; break; end
    end
    chk("sm_wait_line3", {31'd0, found}, 32'd1);
    en_sm = 1'b0;
    fs_before = fs_cnt_sm;
    de_before = de_cnt_sm;
    repeat (100) @(posedge clk);
    chk("sm_de_after_disable", de_cnt_sm - de_before, 32'd8);
    chk("sm_no_fs_after_disable", fs_cnt_sm, fs_before);
    #1 en_sm = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("sm_reenable_fs", {31'd0, sm_fs}, 32'd1);

    // Asynchronous reset in the middle of an active line.
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (m_run && m_v == 3 && m_h == 4) begin found = 1'b1; break; end
    end
    chk("sm_wait_midline", {31'd0, found}, 32'd1);
    @(negedge clk);
    chk("sm_pre_reset_de", {31'd0, sm_de}, 32'd1);
    #2 rst_n = 1'b0; en_sm = 1'b0;
    #1 check_idle_sm("async_rst_sm");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    #1 check_idle_sm("post_rst_idle_sm");
    chk("df_idle_hs", {31'd0, df_hs}, 32'd1);

    // Default 640x480 instance: vector table plus hsync/de run lengths.
    @(posedge clk); #1 en_df = 1'b1;
    @(posedge clk);
    idx = 0; hs_low = 0; de_run = 0; last_fall = -1; n_fall = 0; prev_hs = 1'b1;
    t_end = 36*800 + 200;
    for (int t = 0; t <= t_end; t++) begin
      @(negedge clk);
      if (t == 0) chk("df_enable_fs", {31'd0, df_fs}, 32'd1);
      if (t == 1) chk("df_fs_one_cycle", {31'd0, df_fs}, 32'd0);
      if (t < 800 && !df_hs) hs_low++;
      if (t == 799) chk("df_hs_width", hs_low, 32'd96);
      if (t >= 35*800 && t < 36*800 && df_de) de_run++;
      if (t == 36*800 - 1) chk("df_de_per_line", de_run, 32'd640);
      if (prev_hs && !df_hs) begin
        if (last_fall >= 0 && n_fall < 3) begin
          chk("df_line_period", t - last_fall, 32'd800);
          n_fall++;
        end
        last_fall = t;
      end
      prev_hs = df_hs;
      if (idx < NV && t == tbl[idx].v*800 + tbl[idx].h) begin
        chk("tbl_hs", {31'd0, df_hs}, {31'd0, tbl[idx].hs});
        chk("tbl_vs", {31'd0, df_vs}, {31'd0, tbl[idx].vs});
        chk("tbl_de", {31'd0, df_de}, {31'd0, tbl[idx].de});
        chk("tbl_xpos", {21'd0, df_x}, tbl[idx].x);
        chk("tbl_ypos", {21'd0, df_y}, tbl[idx].y);
        chk("tbl_rgb", {16'd0, df_rgb}, {16'd0, tbl[idx].rgb});
        idx++;
      end
    end
    chk("tbl_all_applied", idx, NV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
